// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined binary32 adder (x1 + x2).
// Stage 1 unpacks and aligns. Stage 2 adds and normalizes. Stage 3 rounds
// to nearest-even and selects special results. All stages advance together
// whenever the output register is empty or being drained.
module fadd_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    logic        adv;
    logic        v1, v2, v3;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    logic        s_a, s_b;
    logic [7:0]  e_a, e_b;
    logic [22:0] f_a, f_b;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [8:0]  ee_a, ee_b;
    logic [23:0] m_a, m_b;
    logic        swap;
    logic        sbig_c, ssmall_c;
    logic [8:0]  ebig_c, esmall_c, ediff;
    logic [23:0] mbig_c, msmall_c;
    logic [4:0]  shamt;
    logic [57:0] align_ext;
    logic [26:0] mb_c, ms_c;
    logic        st_c;
    logic        sp_c;
    logic [31:0] spy_c;

    // Unpack both operands, order them by magnitude and align the smaller one.
    always_comb begin
        s_a   = x1[31];
        e_a   = x1[30:23];
        f_a   = x1[22:0];
        s_b   = x2[31];
        e_b   = x2[30:23];
        f_b   = x2[22:0];
        nan_a = (e_a == 8'hFF) && (f_a != 23'd0);
        nan_b = (e_b == 8'hFF) && (f_b != 23'd0);
        inf_a = (e_a == 8'hFF) && (f_a == 23'd0);
        inf_b = (e_b == 8'hFF) && (f_b == 23'd0);
        // Subnormals use effective exponent 1 with a zero hidden bit.
        ee_a  = (e_a == 8'd0) ? 9'd1 : {1'b0, e_a};
        ee_b  = (e_b == 8'd0) ? 9'd1 : {1'b0, e_b};
        m_a   = {(e_a != 8'd0), f_a};
        m_b   = {(e_b != 8'd0), f_b};

        // Magnitude order of binary32 matches integer order of bits [30:0].
        swap     = x2[30:0] > x1[30:0];
        sbig_c   = swap ? s_b  : s_a;
        ssmall_c = swap ? s_a  : s_b;
        ebig_c   = swap ? ee_b : ee_a;
        esmall_c = swap ? ee_a : ee_b;
        mbig_c   = swap ? m_b  : m_a;
        msmall_c = swap ? m_a  : m_b;

        ediff = ebig_c - esmall_c;
        shamt = (ediff > 9'd31) ? 5'd31 : ediff[4:0];

        // Extra 31 low bits catch everything shifted past the round bit.
        align_ext = {1'b0, msmall_c, 2'b00, 31'd0} >> shamt;
        ms_c      = align_ext[57:31];
        st_c      = |align_ext[30:0];
        mb_c      = {1'b0, mbig_c, 2'b00};

        sp_c  = 1'b1;
        spy_c = 32'd0;
        if (nan_a)
            spy_c = {s_a, 8'hFF, 1'b1, f_a[21:0]};
        else if (nan_b)
            spy_c = {s_b, 8'hFF, 1'b1, f_b[21:0]};
        else if (inf_a && inf_b && (s_a != s_b))
            spy_c = 32'hFFC0_0000;
        else if (inf_a)
            spy_c = x1;
        else if (inf_b)
            spy_c = x2;
        else
            sp_c = 1'b0;
    end

    logic        sp1, sb1, ss1, st1;
    logic [31:0] spy1;
    logic [8:0]  eb1;
    logic [26:0] mb1, ms1;

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            sp1  <= 1'b0;
            spy1 <= 32'd0;
            sb1  <= 1'b0;
            ss1  <= 1'b0;
            eb1  <= 9'd1;
            mb1  <= 27'd0;
            ms1  <= 27'd0;
            st1  <= 1'b0;
        end else if (adv) begin
            v1   <= in_valid;
            sp1  <= sp_c;
            spy1 <= spy_c;
            sb1  <= sbig_c;
            ss1  <= ssmall_c;
            eb1  <= ebig_c;
            mb1  <= mb_c;
            ms1  <= ms_c;
            st1  <= st_c;
        end
    end

    // ---------------- stage 2: add/subtract and normalize ----------------
    logic [27:0] sum_c;
    logic [4:0]  lz;
    logic [8:0]  lshift;
    logic [27:0] norm_ext;
    logic [26:0] r_c;
    logic        sk_c;
    logic [8:0]  e2_c;
    logic        sg_c;

    // Sticky rides as the lowest bit so a subtraction borrows through it.
    always_comb begin
        if (sb1 == ss1)
            sum_c = {mb1, 1'b0} + {ms1, st1};
        else
            sum_c = {mb1, 1'b0} - {ms1, st1};

        lz = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (sum_c[1 + i])
                lz = 5'(25 - i);
        end

        lshift   = 9'd0;
        norm_ext = sum_c;
        if (sum_c[27]) begin
            r_c  = {1'b0, sum_c[27:2]};
            sk_c = sum_c[1] | sum_c[0];
            e2_c = eb1 + 9'd1;
        end else begin
            // Never shift the exponent below 1; what remains is subnormal.
            lshift   = ({4'd0, lz} < (eb1 - 9'd1)) ? {4'd0, lz} : (eb1 - 9'd1);
            norm_ext = sum_c << lshift;
            r_c      = norm_ext[27:1];
            sk_c     = norm_ext[0];
            e2_c     = norm_ext[26] ? (eb1 - lshift) : 9'd0;
        end

        // Exact cancellation gives +0 unless both operands were negative.
        sg_c = (sum_c == 28'd0) ? (sb1 & ss1) : sb1;
    end

    logic        sp2, sg2, sk2;
    logic [31:0] spy2;
    logic [8:0]  e2;
    logic [26:0] r2;

    // Stage 2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            sp2  <= 1'b0;
            spy2 <= 32'd0;
            sg2  <= 1'b0;
            e2   <= 9'd0;
            r2   <= 27'd0;
            sk2  <= 1'b0;
        end else if (adv) begin
            v2   <= v1;
            sp2  <= sp1;
            spy2 <= spy1;
            sg2  <= sg_c;
            e2   <= e2_c;
            r2   <= r_c;
            sk2  <= sk_c;
        end
    end

    // ---------------- stage 3: round and select ----------------
    logic        inc;
    logic [24:0] m25;
    logic [8:0]  e3;
    logic [22:0] frac;
    logic [31:0] y_c;
    logic        ovf_c;

    // Round to nearest-even, fix up exponent, then pick special or overflow.
    always_comb begin
        inc  = r2[1] & (r2[0] | sk2 | r2[2]);
        m25  = {1'b0, r2[25:2]} + {24'd0, inc};
        e3   = e2;
        frac = m25[22:0];
        if (m25[24]) begin
            e3   = e2 + 9'd1;
            frac = m25[23:1];
        end else if ((e2 == 9'd0) && m25[23]) begin
            // Subnormal rounded up into the smallest normal.
            e3 = 9'd1;
        end

        y_c   = {sg2, e3[7:0], frac};
        ovf_c = 1'b0;
        if (sp2) begin
            y_c = spy2;
        end else if (e3 >= 9'd255) begin
            y_c   = {sg2, 8'hFF, 23'd0};
            ovf_c = 1'b1;
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3  <= 1'b0;
            y   <= 32'd0;
            ovf <= 1'b0;
        end else if (adv) begin
            v3  <= v2;
            y   <= y_c;
            ovf <= ovf_c;
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: directed vectors for the pipelined binary32 adder, plus
// backpressure and mid-stream reset sequences.
module tb_fadd_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;

    int n_vec;
    int n_bad;

    fadd_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    logic [31:0] bp_a [5];
    logic [31:0] bp_y [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int acc;
        int nout;

        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0};
        vecs[2]  = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0};
        vecs[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
        vecs[4]  = '{32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00001, 1'b0};
        vecs[6]  = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
        vecs[7]  = '{32'h007FFFFF, 32'h00000001, 32'h00800000, 1'b0};
        vecs[8]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0};
        vecs[9]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0};
        vecs[10] = '{32'h40000000, 32'hBF800000, 32'h3F800000, 1'b0};
        vecs[11] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[12] = '{32'hC0400000, 32'h3F800000, 32'hC0000000, 1'b0};
        vecs[13] = '{32'h3F800000, 32'hFF800001, 32'hFFC00001, 1'b0};
        vecs[14] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0};
        vecs[15] = '{32'hFF800000, 32'hFF800000, 32'hFF800000, 1'b0};
        vecs[16] = '{32'h00800000, 32'h80000001, 32'h007FFFFF, 1'b0};
        vecs[17] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0};
        vecs[18] = '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, 1'b0};

        // n + 1.0 for n = 1..5
        bp_a[0] = 32'h3F800000; bp_y[0] = 32'h40000000;
        bp_a[1] = 32'h40000000; bp_y[1] = 32'h40400000;
        bp_a[2] = 32'h40400000; bp_y[2] = 32'h40800000;
        bp_a[3] = 32'h40800000; bp_y[3] = 32'h40A00000;
        bp_a[4] = 32'h40A00000; bp_y[4] = 32'h40C00000;

        // ---- reset state ----
        rst       = 1'b1;
        in_valid  = 1'b0;
        x1        = 32'd0;
        x2        = 32'd0;
        out_ready = 1'b1;
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset y", y, 32'd0);
        check("reset ovf", {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // ---- table: one beat each, checks 3-cycle latency too ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            x1        = vecs[i].a;
            x2        = vecs[i].b;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d valid k", i), {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid k+1", i), {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid k+2", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d y", i), y, vecs[i].y);
            check($sformatf("vec%0d ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
        end

        // ---- backpressure: stall output, push 5 ops ----
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            x1        = bp_a[acc];
            x2        = 32'h3F800000;
            #1;
            check($sformatf("bp in_ready c%0d", c), {31'd0, in_ready}, (c < 3) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                check($sformatf("bp stalled y c%0d", c), y, bp_y[0]);
                check($sformatf("bp stalled valid c%0d", c), {31'd0, out_valid}, 32'd1);
            end
            if (in_ready) acc++;
        end
        check("bp accepted while stalled", acc, 3);

        nout = 0;
        for (int c = 0; c < 30 && nout < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (acc < 5) begin
                in_valid = 1'b1;
                x1       = bp_a[acc];
                x2       = 32'h3F800000;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                check($sformatf("bp drain y%0d", nout), y, bp_y[nout]);
                nout++;
            end
            if (in_valid && in_ready) acc++;
        end
        check("bp results drained", nout, 5);
        check("bp ops accepted", acc, 5);

        // ---- reset with operations in flight ----
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            x1       = bp_a[j];
            x2       = 32'h3F800000;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("pre-reset valid", {31'd0, out_valid}, 32'd1);
        check("pre-reset y", y, bp_y[0]);
        #1;
        rst = 1'b1;
        #1;
        check("async reset valid", {31'd0, out_valid}, 32'd0);
        check("async reset y", y, 32'd0);
        check("async reset ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("no stale output c%0d", c), {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        x1       = 32'h3F800000;
        x2       = 32'h3F800000;
        in_valid = 1'b1;
        #1;
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post-reset valid k", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post-reset valid k+1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post-reset valid k+2", {31'd0, out_valid}, 32'd1);
        check("post-reset y", y, 32'h40000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Pipelined IEEE 754 binary32 adder (x1 + x2), companion to the combinational subtractor in the FPU.
- Three register stages with valid/ready handshakes on both sides, so the CPU execute unit can issue one add per cycle and absorb writeback backpressure.
- Numeric behaviour matches the subtractor with the x2 sign not inverted: round-to-nearest-even, full subnormal support, same NaN and overflow conventions.

Parameters:
- none (format fixed at binary32; the depth of 3 stages is fixed by this spec).

Ports:
- clk        input   1   clock; all state updates on its rising edge
- rst        input   1   asynchronous, active-high reset
- in_valid   input   1   x1/x2 carry an operation this cycle
- in_ready   output  1   block accepts the operation this cycle
- x1         input   32  operand 1, binary32
- x2         input   32  operand 2, binary32
- out_valid  output  1   y/ovf hold a result
- out_ready  input   1   consumer takes the result this cycle
- y          output  32  x1 + x2, binary32
- ovf        output  1   finite operands produced a rounded result of ±inf

Behaviour:
- Reset: asynchronous, active-high.
  - All stage-valid bits clear immediately. y=0 and ovf=0 are registered.
  - in_ready=1 once rst is released.
  - Assertion mid-operation discards every in-flight operation; nothing is emitted for them.
- Pipeline control: single global advance, adv = ~out_valid | out_ready.
  - in_ready = adv.
  - On adv, every stage loads from the previous one, and stage 1 loads {in_valid, x1, x2}.
  - When adv=0, all stages hold.
  - Bubbles are not collapsed. Ordering is strictly FIFO.
- Transfers: an input is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready.
- Latency: an operation accepted at edge k appears at the outputs (out_valid=1) after edge k+2, i.e. 3 cycles. Throughput is 1 per cycle while out_ready=1.
- y and ovf are stable while out_valid=1 and out_ready=0.
- Stage 1, unpack and align:
  - Subnormal operands (e=0): hidden bit 0, effective exponent 1. Normal operands: hidden bit 1.
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Swap so the larger-magnitude operand is "big". When exponents are equal, compare mantissas.
  - Right-shift the small mantissa by the exponent difference, saturated at 31, into a 27-bit field (guard, round, sticky). Every bit shifted out ORs into sticky.
- Stage 2, add and normalize:
  - Add the mantissas if signs are equal, otherwise subtract small from big.
  - On carry-out: shift right 1, exponent+1, and OR the lost bit into sticky.
  - Otherwise: leading-zero count, then shift left.
  - The left shift is limited so the exponent does not fall below 1. The result then stays subnormal with biased exponent 0.
- Stage 3, round and select:
  - RNE: increment when guard & (round | sticky | lsb).
  - A mantissa carry from rounding increments the exponent.
  - Biased exponent reaching 255 from finite inputs gives y=±inf (mantissa 0) and ovf=1.
  - Exact zero result: sign = s1 & s2. So (+0)+(-0)=+0, (-0)+(-0)=-0, and x+(-x)=+0.
- Special cases, in priority order:
  - x1 NaN: y = {s1, 255, 1, m1[21:0]}.
  - Else x2 NaN: y = {s2, 255, 1, m2[21:0]}.
  - inf + (-inf): y = 0xFFC00000.
  - Otherwise any inf: y = that inf.
  - ovf=0 for all special cases.
- Width rules:
  - Internal exponent 9 bits with a sign guard.
  - Mantissa path 27 bits: carry, hidden, 23 fraction, guard, round. Sticky is kept separately.

Test Plan:
- 0x3F800000 + 0x40000000, one beat, out_ready=1 -> y=0x40400000, ovf=0. out_valid high exactly 3 cycles after the accepting edge.
- 0x3F800000 + 0xBF800000 -> y=0x00000000. 0x80000000 + 0x80000000 -> y=0x80000000.
- 0x7F7FFFFF + 0x7F7FFFFF -> y=0x7F800000, ovf=1. Then 0x7F800000 + 0xFF800000 -> y=0xFFC00000, ovf=0. Then 0x7FC00001 + 0x3F800000 -> y=0x7FC00001.
- Subnormal and rounding:
  - 0x00000001 + 0x00000001 -> 0x00000002.
  - 0x007FFFFF + 0x00000001 -> 0x00800000.
  - 0x3F800000 + 0x33800000 (1 + 2^-24, a tie) -> 0x3F800000.
  - 0x3F800001 + 0x33800000 -> 0x3F800002.
- Backpressure: out_ready=0, in_valid=1 continuously with 5 distinct ops.
  - in_ready=1 for cycles 0-2, then 0 from cycle 3. Exactly 3 ops are accepted.
  - y stays constant while stalled.
  - Raising out_ready drains the 3 results in order, then accepts ops 4-5.
- Reset mid-stream: assert rst with 2 ops in flight. out_valid=0, y=0 and ovf=0 immediately (asynchronously). After release, the next op emerges with correct y 3 cycles after acceptance, and no stale result appears.
